decode_regfile: RTL and testbench

//   Instruction-decode stage of the single-cycle MiniSys CPU, directly upstream of the execute/ALU stage.

---
 rtl/decode_regfile.sv | 69 ++++++
 tb/tb_decode_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/decode_regfile.sv
// Decode stage of the single-cycle MiniSys CPU. It holds the 32x32 register file, provides the
// operand reads and the immediate extension, and commits write-back on the rising clock edge.
module decode_regfile #(
  parameter logic [31:0] SP_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] opcplus4,
  input  logic [31:0] ALU_result,
  input  logic [31:0] mem_data,
  input  logic        Jal,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic        RegDst,
  output logic [31:0] read_data_1,
  output logic [31:0] read_data_2,
  output logic [31:0] Sign_extend
);

  localparam int unsigned NREG = 32;
  localparam int unsigned XLEN = 32;
  localparam logic [4:0]  SP_IDX = 5'd29;
  localparam logic [4:0]  RA_IDX = 5'd31;

  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  logic [NREG-1:0][XLEN-1:0] r_regs;

  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [15:0]     w_imm;
  logic [4:0]      w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_we;
  logic            w_zext;

  assign w_op  = Instruction[31:26];
  assign w_rs  = Instruction[25:21];
  assign w_rt  = Instruction[20:16];
  assign w_rd  = Instruction[15:11];
  assign w_imm = Instruction[15:0];

  // Jal has priority over both the destination select and the data select.
  assign w_waddr = Jal ? RA_IDX : (RegDst ? w_rd : w_rt);
  assign w_wdata = Jal ? opcplus4 : (MemtoReg ? mem_data : ALU_result);
  assign w_we    = (RegWrite | Jal) & ~reset & (w_waddr != 5'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_regs         <= '0;
      r_regs[SP_IDX] <= SP_RESET;
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  // The old value is read during a pending write; the new value appears after the edge.
  assign read_data_1 = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
  assign read_data_2 = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

  assign w_zext      = (w_op == OP_ANDI) | (w_op == OP_ORI) | (w_op == OP_XORI);
  assign Sign_extend = w_zext ? {16'h0000, w_imm} : {{16{w_imm[15]}}, w_imm};

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: reset state, write-back paths, $0 handling, Jal priority,
// reset overriding a write, and immediate extension.
module tb_decode_regfile;

  logic        clock;
  logic        reset;
  logic [31:0] Instruction;
  logic [31:0] opcplus4;
  logic [31:0] ALU_result;
  logic [31:0] mem_data;
  logic        Jal;
  logic        RegWrite;
  logic        MemtoReg;
  logic        RegDst;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] Sign_extend;

  int n_chk;
  int n_fail;

  decode_regfile #(.SP_RESET(32'h0000_7FFC)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .Instruction (Instruction),
    .opcplus4    (opcplus4),
    .ALU_result  (ALU_result),
    .mem_data    (mem_data),
    .Jal         (Jal),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .Sign_extend (Sign_extend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive an R-type-shaped instruction word so rs/rt/rd are all controllable.
  task automatic set_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    Instruction = {6'd0, rs, rt, rd, 11'd0};
    #1;
  endtask

  task automatic ctl_idle();
    RegWrite = 1'b0; Jal = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_ext(input string tag, input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] exp);
    Instruction = {op, 5'd0, 5'd0, imm};
    #1;
    chk(tag, Sign_extend, exp);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; Instruction = '0; opcplus4 = '0; ALU_result = '0; mem_data = '0;
    ctl_idle();
    RegWrite = 1'b1; ALU_result = 32'hFFFF_FFFF; Instruction = {6'd0, 5'd0, 5'd3, 5'd3, 11'd0};
    tick();
    tick();
    reset = 1'b0;
    ctl_idle();

    // Reset state
    set_ins(5'd29, 5'd31, 5'd0);
    chk("rst_sp", read_data_1, 32'h0000_7FFC);
    chk("rst_r31", read_data_2, 32'h0);
    set_ins(5'd5, 5'd3, 5'd0);
    chk("rst_r5", read_data_1, 32'h0);
    chk("rst_r3_no_write", read_data_2, 32'h0);

    // ALU write to rd=8: no bypass, value appears after the edge
    RegWrite = 1'b1; RegDst = 1'b1; ALU_result = 32'hDEAD_BEEF; mem_data = 32'h1111_1111;
    set_ins(5'd8, 5'd8, 5'd8);
    chk("r8_old_rs", read_data_1, 32'h0);
    chk("r8_old_rt", read_data_2, 32'h0);
    tick();
    chk("r8_new", read_data_1, 32'hDEAD_BEEF);
    ctl_idle();

    // Write to $0 is discarded
    RegWrite = 1'b1; RegDst = 1'b0; ALU_result = 32'h0000_1234;
    set_ins(5'd0, 5'd0, 5'd8);
    tick();
    chk("r0_rs", read_data_1, 32'h0);
    chk("r0_rt", read_data_2, 32'h0);
    ctl_idle();
    set_ins(5'd8, 5'd29, 5'd0);
    chk("r8_kept", read_data_1, 32'hDEAD_BEEF);
    chk("sp_kept", read_data_2, 32'h0000_7FFC);

    // Jal beats RegDst and MemtoReg
    Jal = 1'b1; RegDst = 1'b1; MemtoReg = 1'b1; opcplus4 = 32'h0000_0040;
    mem_data = 32'h5555_5555; ALU_result = 32'h6666_6666;
    set_ins(5'd4, 5'd31, 5'd4);
    tick();
    ctl_idle();
    set_ins(5'd31, 5'd4, 5'd0);
    chk("jal_r31", read_data_1, 32'h0000_0040);
    chk("jal_r4", read_data_2, 32'h0);

    // Jal together with RegWrite still lands in $31 only
    Jal = 1'b1; RegWrite = 1'b1; RegDst = 1'b1; opcplus4 = 32'h0000_0100;
    set_ins(5'd0, 5'd0, 5'd12);
    tick();
    ctl_idle();
    set_ins(5'd31, 5'd12, 5'd0);
    chk("jal_rw_r31", read_data_1, 32'h0000_0100);
    chk("jal_rw_r12", read_data_2, 32'h0);

    // No enable: nothing changes
    MemtoReg = 1'b1; RegDst = 1'b1; ALU_result = 32'h7777_7777; mem_data = 32'h8888_8888;
    set_ins(5'd8, 5'd10, 5'd8);
    tick();
    chk("idle_r8", read_data_1, 32'hDEAD_BEEF);
    chk("idle_r10", read_data_2, 32'h0);
    ctl_idle();

    // Memory write-back to rt=9
    RegWrite = 1'b1; MemtoReg = 1'b1; RegDst = 1'b0;
    mem_data = 32'hA5A5_0001; ALU_result = 32'h0BAD_0BAD;
    set_ins(5'd9, 5'd9, 5'd2);
    tick();
    chk("lw_r9", read_data_1, 32'hA5A5_0001);

    // Reset with a concurrent write: reset wins and all state is lost
    reset = 1'b1; mem_data = 32'hCAFE_F00D;
    tick();
    reset = 1'b0;
    ctl_idle();
    set_ins(5'd9, 5'd8, 5'd0);
    chk("rst_r9", read_data_1, 32'h0);
    chk("rst_r8", read_data_2, 32'h0);
    set_ins(5'd31, 5'd29, 5'd0);
    chk("rst_r31b", read_data_1, 32'h0);
    chk("rst_spb", read_data_2, 32'h0000_7FFC);

    // Register 29 is an ordinary writable register after reset
    RegWrite = 1'b1; RegDst = 1'b1; ALU_result = 32'h0000_7FF0;
    set_ins(5'd29, 5'd0, 5'd29);
    tick();
    ctl_idle();
    chk("sp_write", read_data_1, 32'h0000_7FF0);

    // Immediate extension
    chk_ext("ext_ori",   6'b001101, 16'h8001, 32'h0000_8001);
    chk_ext("ext_andi",  6'b001100, 16'h8001, 32'h0000_8001);
    chk_ext("ext_xori",  6'b001110, 16'hFFFF, 32'h0000_FFFF);
    chk_ext("ext_addiu", 6'b001001, 16'h8001, 32'hFFFF_8001);
    chk_ext("ext_sltiu", 6'b001011, 16'h8001, 32'hFFFF_8001);
    chk_ext("ext_lui",   6'b001111, 16'h8000, 32'hFFFF_8000);
    chk_ext("ext_lw",    6'b100011, 16'h7FFF, 32'h0000_7FFF);
    chk_ext("ext_beq",   6'b000100, 16'hFFFE, 32'hFFFF_FFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
